// File: rtl/param_updown_counter.sv
// param_updown_counter: fully synchronous up/down counter with a programmable
// range 0..MAX_VALUE, parallel load with clamping, wrap or saturate behaviour
// at the range ends, and a combinational terminal count for cascading stages.
module param_updown_counter #(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] q_reg, q_next;
    logic             wrap_reg, wrap_next;
    logic             sat_reg, sat_next;
    logic [WIDTH-1:0] load_clamped;
    logic             at_max, at_zero;
    logic             load_at_limit;

    // A full-range counter can never be loaded above its top value, so the
    // clamp comparator only exists when the range is truncated.
    generate
        if (MAX_VALUE == ((64'd1 << WIDTH) - 64'd1)) begin : g_no_clamp
            assign load_clamped = load_val;
        end else begin : g_clamp
            assign load_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;
        end
    endgenerate

    assign at_max  = (q_reg == MAX_Q);
    assign at_zero = (q_reg == '0);

    // A loaded value sitting at the limit of the current direction saturates
    // immediately when counting is also requested.
    assign load_at_limit = up ? (load_clamped == MAX_Q) : (load_clamped == '0);

    // Terminal count is combinational so a following stage can use it as its
    // enable in the same cycle; suppressed whenever a higher-priority control
    // will override counting on this edge.
    assign tc = en & ~reset & ~clear & ~load &
                ((up & at_max) | (~up & at_zero));

    // Next-state selection: clear > load > count > hold (reset handled in the register).
    always_comb begin
        q_next    = q_reg;
        wrap_next = 1'b0;
        sat_next  = 1'b0;
        if (clear) begin
            q_next = '0;
        end else if (load) begin
            q_next   = load_clamped;
            sat_next = SATURATE & en & load_at_limit;
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    q_next = q_reg + ONE;
                end else if (SATURATE) begin
                    sat_next = 1'b1;
                end else begin
                    q_next    = '0;
                    wrap_next = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    q_next = q_reg - ONE;
                end else if (SATURATE) begin
                    sat_next = 1'b1;
                end else begin
                    q_next    = MAX_Q;
                    wrap_next = 1'b1;
                end
            end
        end
    end

    // State register with synchronous reset that wins over every other control.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg    <= '0;
            wrap_reg <= 1'b0;
            sat_reg  <= 1'b0;
        end else begin
            q_reg    <= q_next;
            wrap_reg <= wrap_next;
            sat_reg  <= sat_next;
        end
    end

    assign q    = q_reg;
    assign wrap = wrap_reg;
    assign sat  = sat_reg;

endmodule

// File: tb/tb_param_updown_counter.sv
// Testbench for param_updown_counter: wrap-mode, saturate-mode and 1-bit
// instances driven from vector tables, plus a two-stage decade cascade.
module tb_param_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=4, MAX_VALUE=9, wrap mode
    logic a_reset, a_clear, a_load, a_en, a_up;
    logic [3:0] a_lv, a_q;
    logic a_tc, a_wrap, a_sat;
    param_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b0)) u_a (
        .clk(clk), .reset(a_reset), .clear(a_clear), .load(a_load), .load_val(a_lv),
        .en(a_en), .up(a_up), .q(a_q), .tc(a_tc), .wrap(a_wrap), .sat(a_sat));

    // Instance B: WIDTH=4, MAX_VALUE=9, saturate mode
    logic b_reset, b_clear, b_load, b_en, b_up;
    logic [3:0] b_lv, b_q;
    logic b_tc, b_wrap, b_sat;
    param_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b1)) u_b (
        .clk(clk), .reset(b_reset), .clear(b_clear), .load(b_load), .load_val(b_lv),
        .en(b_en), .up(b_up), .q(b_q), .tc(b_tc), .wrap(b_wrap), .sat(b_sat));

    // Instance C: WIDTH=1, full range, wrap mode
    logic c_reset, c_clear, c_load, c_en, c_up;
    logic [0:0] c_lv, c_q;
    logic c_tc, c_wrap, c_sat;
    param_updown_counter #(.WIDTH(1), .MAX_VALUE(1), .SATURATE(1'b0)) u_c (
        .clk(clk), .reset(c_reset), .clear(c_clear), .load(c_load), .load_val(c_lv),
        .en(c_en), .up(c_up), .q(c_q), .tc(c_tc), .wrap(c_wrap), .sat(c_sat));

    // Two-stage decade cascade: stage0 tc drives stage1 en
    logic k_reset, k_en;
    logic [3:0] k_q0, k_q1;
    logic k_tc0, k_tc1, k_w0, k_w1, k_s0, k_s1;
    param_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b0)) u_k0 (
        .clk(clk), .reset(k_reset), .clear(1'b0), .load(1'b0), .load_val(4'd0),
        .en(k_en), .up(1'b1), .q(k_q0), .tc(k_tc0), .wrap(k_w0), .sat(k_s0));
    param_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b0)) u_k1 (
        .clk(clk), .reset(k_reset), .clear(1'b0), .load(1'b0), .load_val(4'd0),
        .en(k_tc0), .up(1'b1), .q(k_q1), .tc(k_tc1), .wrap(k_w1), .sat(k_s1));

    typedef struct {
        logic       rst, clr, ld;
        logic [3:0] lv;
        logic       en, up;
        logic       tc;      // expected tc before the edge
        logic [3:0] q;       // expected after the edge
        logic       w, s;
    } vec_t;

    typedef struct {
        string      name;
        int         dut;
        logic [3:0] q;
        logic       w, s;
    } exp_t;

    exp_t sbq[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic vec_t mk(input int rst, input int clr, input int ld, input int lv,
                                input int en, input int up, input int tc, input int q,
                                input int w, input int s);
        vec_t v;
        v.rst = rst[0]; v.clr = clr[0]; v.ld = ld[0]; v.lv = 4'(lv);
        v.en = en[0]; v.up = up[0]; v.tc = tc[0]; v.q = 4'(q);
        v.w = w[0]; v.s = s[0];
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input int d, input vec_t v);
        case (d)
            0: begin a_reset = v.rst; a_clear = v.clr; a_load = v.ld; a_lv = v.lv; a_en = v.en; a_up = v.up; end
            1: begin b_reset = v.rst; b_clear = v.clr; b_load = v.ld; b_lv = v.lv; b_en = v.en; b_up = v.up; end
            default: begin c_reset = v.rst; c_clear = v.clr; c_load = v.ld; c_lv = v.lv[0:0]; c_en = v.en; c_up = v.up; end
        endcase
    endtask

    function automatic int dq(input int d);
        case (d)
            0: return int'(a_q);
            1: return int'(b_q);
            default: return int'(c_q);
        endcase
    endfunction
    function automatic int dtc(input int d);
        case (d)
            0: return int'(a_tc);
            1: return int'(b_tc);
            default: return int'(c_tc);
        endcase
    endfunction
    function automatic int dw(input int d);
        case (d)
            0: return int'(a_wrap);
            1: return int'(b_wrap);
            default: return int'(c_wrap);
        endcase
    endfunction
    function automatic int ds(input int d);
        case (d)
            0: return int'(b_sat & 1'b0) + int'(a_sat);
            1: return int'(b_sat);
            default: return int'(c_sat);
        endcase
    endfunction

    // Drive one vector at the falling edge, check tc, queue the expected
    // registered result and compare it after the next rising edge.
    task automatic run_vec(input int d, input string nm, input vec_t v);
        exp_t e;
        drive(d, v);
        #1;
        check({nm, "_tc"}, dtc(d), int'(v.tc));
        e.name = nm; e.dut = d; e.q = v.q; e.w = v.w; e.s = v.s;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check({e.name, "_q"},    dq(e.dut), int'(e.q));
        check({e.name, "_wrap"}, dw(e.dut), int'(e.w));
        check({e.name, "_sat"},  ds(e.dut), int'(e.s));
        $display("txn %s dut%0d q=%0d wrap=%0d sat=%0d", e.name, e.dut, dq(e.dut), dw(e.dut), ds(e.dut));
        @(negedge clk);
    endtask

    vec_t tab_a[$];
    vec_t tab_b[$];
    vec_t tab_c[$];

    initial begin
        //            rst clr ld lv en up tc  q  w  s
        // reset for two cycles (second with en/up=0 that would otherwise be terminal)
        tab_a.push_back(mk(1,0,0, 0,0,0, 0, 0,0,0));
        tab_a.push_back(mk(1,0,0, 0,1,0, 0, 0,0,0));
        // count up 12 cycles: 1..9,0,1,2
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 1,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 2,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 3,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 4,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 5,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 6,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 7,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 8,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 9,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 1, 0,1,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 1,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 2,0,0));
        // load 9, then clear at q=9 with en/up (tc suppressed)
        tab_a.push_back(mk(0,0,1, 9,1,1, 0, 9,0,0));
        tab_a.push_back(mk(0,1,0, 0,1,1, 0, 0,0,0));
        // count down from 0: 9,8,7
        tab_a.push_back(mk(0,0,0, 0,1,0, 1, 9,1,0));
        tab_a.push_back(mk(0,0,0, 0,1,0, 0, 8,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,0, 0, 7,0,0));
        tab_a.push_back(mk(0,0,0, 0,0,0, 0, 7,0,0));
        // load clamp, wrap, load beats en, clear beats load
        tab_a.push_back(mk(0,0,1,13,0,0, 0, 9,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 1, 0,1,0));
        tab_a.push_back(mk(0,0,1, 3,1,1, 0, 3,0,0));
        tab_a.push_back(mk(0,1,1, 5,0,0, 0, 0,0,0));
        // count to 6, reset mid-count, reset with load, resume
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 1,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 2,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 3,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 4,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 5,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 6,0,0));
        tab_a.push_back(mk(1,0,0, 0,1,1, 0, 0,0,0));
        tab_a.push_back(mk(1,0,1, 5,1,1, 0, 0,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 0, 1,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,0, 0, 0,0,0));
        // tc needs en; wrap clears when en drops
        tab_a.push_back(mk(0,0,1, 9,0,1, 0, 9,0,0));
        tab_a.push_back(mk(0,0,0, 0,0,1, 0, 9,0,0));
        tab_a.push_back(mk(0,0,0, 0,1,1, 1, 0,1,0));
        tab_a.push_back(mk(0,0,0, 0,0,1, 0, 0,0,0));

        // saturate mode
        tab_b.push_back(mk(1,0,0, 0,0,0, 0, 0,0,0));
        tab_b.push_back(mk(0,0,1, 8,0,0, 0, 8,0,0));
        tab_b.push_back(mk(0,0,0, 0,1,1, 0, 9,0,0));
        tab_b.push_back(mk(0,0,0, 0,1,1, 1, 9,0,1));
        tab_b.push_back(mk(0,0,0, 0,1,1, 1, 9,0,1));
        tab_b.push_back(mk(0,0,0, 0,1,1, 1, 9,0,1));
        tab_b.push_back(mk(0,0,0, 0,1,0, 0, 8,0,0));
        tab_b.push_back(mk(0,0,1, 0,1,0, 0, 0,0,1));
        tab_b.push_back(mk(0,0,0, 0,1,0, 1, 0,0,1));
        tab_b.push_back(mk(0,0,0, 0,0,0, 0, 0,0,0));
        tab_b.push_back(mk(0,0,1, 9,1,0, 0, 9,0,0));
        tab_b.push_back(mk(0,0,1,15,1,1, 0, 9,0,1));
        tab_b.push_back(mk(0,1,0, 0,1,1, 0, 0,0,0));

        // 1-bit counter
        tab_c.push_back(mk(1,0,0, 0,0,0, 0, 0,0,0));
        tab_c.push_back(mk(0,0,0, 0,1,1, 0, 1,0,0));
        tab_c.push_back(mk(0,0,0, 0,1,1, 1, 0,1,0));
        tab_c.push_back(mk(0,0,0, 0,1,1, 0, 1,0,0));
        tab_c.push_back(mk(0,0,0, 0,1,0, 0, 0,0,0));
        tab_c.push_back(mk(0,0,0, 0,1,0, 1, 1,1,0));
        tab_c.push_back(mk(0,0,1, 0,0,0, 0, 0,0,0));

        {a_reset, a_clear, a_load, a_en, a_up} = '0; a_lv = '0;
        {b_reset, b_clear, b_load, b_en, b_up} = '0; b_lv = '0;
        {c_reset, c_clear, c_load, c_en, c_up} = '0; c_lv = '0;
        k_reset = 1'b1; k_en = 1'b0;

        @(negedge clk);
        for (int i = 0; i < tab_a.size(); i++) run_vec(0, $sformatf("A%0d", i), tab_a[i]);
        for (int i = 0; i < tab_b.size(); i++) run_vec(1, $sformatf("B%0d", i), tab_b[i]);
        for (int i = 0; i < tab_c.size(); i++) run_vec(2, $sformatf("C%0d", i), tab_c[i]);

        // Cascade: two reset cycles, then 100 enabled cycles stepping 00..99,00
        k_reset = 1'b1; k_en = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); #1;
        check("casc_rst_q0", int'(k_q0), 0);
        check("casc_rst_q1", int'(k_q1), 0);
        @(negedge clk);
        k_reset = 1'b0; k_en = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            #1;
            check($sformatf("casc%0d_tc0", i), int'(k_tc0), ((i - 1) % 10 == 9) ? 1 : 0);
            @(posedge clk); #1;
            check($sformatf("casc%0d_q0", i), int'(k_q0), i % 10);
            check($sformatf("casc%0d_q1", i), int'(k_q1), (i % 100) / 10);
            $display("txn casc%0d q1=%0d q0=%0d", i, k_q1, k_q0);
            @(negedge clk);
        end
        k_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
